// File: rtl/seg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// seg_scan_ctrl_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the 7-segment display path: symbol codes used by the
// sensor path and count formatting, and the scan state type.
// Ports: none (package).
// Revision: 1.0 - initial release
// ============================================================================
package seg_scan_ctrl_pkg;

  // Symbol codes beyond the 0..15 hex glyphs
  localparam logic [4:0] SYM_C     = 5'd16;
  localparam logic [4:0] SYM_A     = 5'd17;
  localparam logic [4:0] SYM_S     = 5'd18;
  localparam logic [4:0] SYM_DASH  = 5'd19;
  localparam logic [4:0] SYM_BLANK = 5'd31;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// seg_scan_ctrl_if
// ----------------------------------------------------------------------------
// Staging write port and commit handshake of the display controller.
// Signals:
//   wr_valid/wr_ready  write handshake, wr_digit (0 = rightmost), wr_sym (5b)
//   commit             one-cycle request to publish staging at frame boundary
//   commit_done        one-cycle pulse when the publish happens
// Modports: master (producer side), slave (seg_scan_ctrl side).
// Revision: 1.0 - initial release
// ============================================================================
interface seg_scan_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_digit;
  logic [4:0] wr_sym;
  logic       commit;
  logic       commit_done;

  modport master (
    output wr_valid, wr_digit, wr_sym, commit,
    input  wr_ready, commit_done
  );

  modport slave (
    input  wr_valid, wr_digit, wr_sym, commit,
    output wr_ready, commit_done
  );
endinterface
`default_nettype wire

// File: rtl/seg_glyph_rom.sv
`default_nettype none
// ============================================================================
// seg_glyph_rom
// ----------------------------------------------------------------------------
// Combinational symbol-to-segment decode, active-low, bit order {g,f,e,d,c,b,a}.
// Ports:
//   sym  in  5  symbol code (0..15 hex, 16 C, 17 A, 18 S, 19 top dash,
//               everything else blank)
//   seg  out 7  active-low segment pattern
// Revision: 1.0 - initial release
// ============================================================================
module seg_glyph_rom
  import seg_scan_ctrl_pkg::*;
(
  input  logic [4:0] sym,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (sym)
      5'd0:     seg = 7'b1000000;
      5'd1:     seg = 7'b1111001;
      5'd2:     seg = 7'b0100100;
      5'd3:     seg = 7'b0110000;
      5'd4:     seg = 7'b0011001;
      5'd5:     seg = 7'b0010010;
      5'd6:     seg = 7'b0000010;
      5'd7:     seg = 7'b1111000;
      5'd8:     seg = 7'b0000000;
      5'd9:     seg = 7'b0010000;
      5'd10:    seg = 7'b0001000;
      5'd11:    seg = 7'b0000011;
      5'd12:    seg = 7'b1000110;
      5'd13:    seg = 7'b0100001;
      5'd14:    seg = 7'b0000110;
      5'd15:    seg = 7'b0001110;
      SYM_C:    seg = 7'b1000110;
      SYM_A:    seg = 7'b0001000;
      SYM_S:    seg = 7'b0010010;
      SYM_DASH: seg = 7'b1111110;
      default:  seg = 7'b1111111;  // reserved codes and SYM_BLANK
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// seg_scan_ctrl
// ----------------------------------------------------------------------------
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment
// display. Each digit slot is DIGIT_CYC cycles, the first BLANK_CYC with all
// anodes off. Symbols are written into staging registers and copied to the
// displayed (active) set atomically at the end of a frame.
// Parameters: DIGIT_CYC (>= 4), BLANK_CYC (1 <= BLANK_CYC < DIGIT_CYC)
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   en     in   display enable, low forces the display dark
//   wr     slave staging write / commit port (seg_scan_ctrl_if)
//   seg    out  7  segments {g,f,e,d,c,b,a}, active-low, registered
//   an     out  4  anodes, active-low, registered, at most one low
// Revision: 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int DIGIT_CYC = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  seg_scan_ctrl_if.slave  wr,
  output logic [6:0]      seg,
  output logic [3:0]      an
);

  localparam int            CW         = $clog2(DIGIT_CYC);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  scan_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic          pending;
  logic          frame_end;
  logic          accept;
  logic [6:0]    glyph;
  logic [4:0]    staging [4];
  logic [4:0]    active  [4];

  // Counter runs across the whole slot; BLANK occupies its first BLANK_CYC
  // counts and DRIVE the remainder.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = (cnt == SLOT_LAST) ? '0 : cnt + 1'b1;
    if (!en) begin
      state_nxt = BLANK;
      cnt_nxt   = '0;
      idx_nxt   = 2'd0;
    end else begin
      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) state_nxt = DRIVE;
        end
        DRIVE: begin
          if (cnt == SLOT_LAST) begin
            state_nxt = BLANK;
            idx_nxt   = idx + 2'd1;
          end
        end
        default: state_nxt = BLANK;
      endcase
    end
  end

  assign frame_end   = en && (state == DRIVE) && (idx == 2'd3) && (cnt == SLOT_LAST);
  assign wr.wr_ready = !pending;
  assign accept      = wr.wr_valid && !pending;

  // Decode the digit that will be shown after this edge so that seg and an
  // update together and the glyph is already stable when the anode turns on.
  seg_glyph_rom u_rom (
    .sym (active[idx_nxt]),
    .seg (glyph)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= BLANK;
      cnt            <= '0;
      idx            <= 2'd0;
      an             <= 4'b1111;
      seg            <= 7'b1111111;
      pending        <= 1'b0;
      wr.commit_done <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        staging[i] <= SYM_BLANK;
        active[i]  <= SYM_BLANK;
      end
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;

      if (en && (state_nxt == DRIVE)) begin
        an  <= ~(4'b0001 << idx_nxt);
        seg <= glyph;
      end else begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
      end

      if (accept) staging[wr.wr_digit] <= wr.wr_sym;

      // With the display disabled there is no frame to wait for, so a
      // pending commit is published immediately.
      wr.commit_done <= 1'b0;
      if (pending && (frame_end || !en)) begin
        for (int i = 0; i < 4; i++) active[i] <= staging[i];
        pending        <= 1'b0;
        wr.commit_done <= 1'b1;
      end else if (wr.commit && !pending) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_seg_scan_ctrl
// ----------------------------------------------------------------------------
// Randomised bench for seg_scan_ctrl with DIGIT_CYC = 8, BLANK_CYC = 2.
// A reference model computes, from the position in the frame, the expected
// outputs after each clock edge and queues them; a monitor pops and compares
// on the falling edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int DIGIT_CYC = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 4 * DIGIT_CYC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [6:0] seg;
  logic [3:0] an;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.DIGIT_CYC(DIGIT_CYC), .BLANK_CYC(BLANK_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .wr    (bus),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       cd;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];

  // Glyphs described by which segments are lit; converted to active-low
  // {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph_ref(input logic [4:0] code);
    string      s;
    logic [6:0] r;
    case (code)
      5'd0:  s = "abcdef";
      5'd1:  s = "bc";
      5'd2:  s = "abdeg";
      5'd3:  s = "abcdg";
      5'd4:  s = "bcfg";
      5'd5:  s = "acdfg";
      5'd6:  s = "acdefg";
      5'd7:  s = "abc";
      5'd8:  s = "abcdefg";
      5'd9:  s = "abcdfg";
      5'd10: s = "abcefg";
      5'd11: s = "cdefg";
      5'd12: s = "adef";
      5'd13: s = "bcdeg";
      5'd14: s = "adefg";
      5'd15: s = "aefg";
      5'd16: s = "adef";
      5'd17: s = "abcefg";
      5'd18: s = "acdfg";
      5'd19: s = "a";
      default: s = "";
    endcase
    r = 7'b1111111;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
    return r;
  endfunction

  // ---------------- reference model ----------------
  int         t;            // cycles since scan (re)start
  logic [4:0] stg [4];
  logic [4:0] act [4];
  bit         pend;
  int         model_cd_cnt = 0;

  always @(posedge clk) begin
    exp_t e;
    bit   boundary;
    int   slot, off;
    e.cd = 1'b0;
    if (!rst_n) begin
      t    = 0;
      pend = 0;
      for (int i = 0; i < 4; i++) begin stg[i] = 5'd31; act[i] = 5'd31; end
    end else begin
      boundary = en && ((t % FRAME) == FRAME - 1);
      if (pend && (!en || boundary)) begin
        for (int i = 0; i < 4; i++) act[i] = stg[i];
        pend = 0;
        e.cd = 1'b1;
        model_cd_cnt++;
        if (bus.wr_valid) ; // blocked: pending was set during this cycle
      end else begin
        if (bus.wr_valid && !pend) stg[bus.wr_digit] = bus.wr_sym;
        if (bus.commit && !pend) pend = 1;
      end
      t = en ? t + 1 : 0;
    end
    e.rdy = !pend;
    e.an  = 4'b1111;
    e.seg = 7'b1111111;
    if (rst_n && en) begin
      slot = (t % FRAME) / DIGIT_CYC;
      off  = t % DIGIT_CYC;
      if (off >= BLANK_CYC) begin
        e.an       = 4'b1111;
        e.an[slot] = 1'b0;
        e.seg      = glyph_ref(act[slot]);
      end
    end
    exp_q.push_back(e);
  end

  // ---------------- monitor ----------------
  int dut_cd_cnt = 0;

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("an",          {3'b000, an},               {3'b000, e.an});
      check("seg",         seg,                        e.seg);
      check("commit_done", {6'd0, bus.commit_done},    {6'd0, e.cd});
      check("wr_ready",    {6'd0, bus.wr_ready},       {6'd0, e.rdy});
      check("an_onehot",   7'($countones(~an) <= 1),   7'd1);
      if (bus.commit_done === 1'b1) dut_cd_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] dsyms [4];
    int en_off = 0;
    dsyms[0] = 5'd16; dsyms[1] = 5'd17; dsyms[2] = 5'd18; dsyms[3] = 5'd5;

    rst_n = 1'b0; en = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_digit = 2'd0; bus.wr_sym = 5'd0; bus.commit = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2 * FRAME) tick();

    // directed: C A S 5 then commit
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1'b1; bus.wr_digit = 2'(i); bus.wr_sym = dsyms[i];
      tick();
    end
    bus.wr_valid = 1'b0; bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    // write attempt while pending, plus an ignored second commit
    bus.wr_valid = 1'b1; bus.wr_digit = 2'd2; bus.wr_sym = 5'd9; bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    repeat (2 * FRAME) tick();
    bus.wr_valid = 1'b0;

    // directed: reserved symbol on digit 3, simultaneous write + commit
    bus.wr_valid = 1'b1; bus.wr_digit = 2'd3; bus.wr_sym = 5'd25;
    tick();
    bus.wr_digit = 2'd1; bus.wr_sym = 5'd19; bus.commit = 1'b1;
    tick();
    bus.wr_valid = 1'b0; bus.commit = 1'b0;
    repeat (2 * FRAME + 5) tick();

    // directed: drop enable with commit pending, then restart
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    repeat (20) tick();
    en = 1'b0;
    repeat (4) tick();
    en = 1'b1;
    repeat (FRAME + 10) tick();

    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      rst_n = !((i == 2000) || (i == 2001) || ($urandom_range(0, 1499) == 0));
      en    = (en_off == 0);
      if (en_off > 0) en_off--;
      else if ($urandom_range(0, 299) == 0) en_off = $urandom_range(1, 6);
      bus.wr_valid = ($urandom_range(0, 2) == 0);
      bus.wr_digit = 2'($urandom_range(0, 3));
      bus.wr_sym   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                 : 5'($urandom_range(0, 19));
      bus.commit   = ($urandom_range(0, 39) == 0);
      tick();
    end

    bus.wr_valid = 1'b0; bus.commit = 1'b0; rst_n = 1'b1; en = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    #1;
    checks++;
    if (dut_cd_cnt != model_cd_cnt) begin
      errors++;
      $display("FAIL commit_done_count: got %0d expected %0d", dut_cd_cnt, model_cd_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
